// File: rtl/rr_hold_scheduler_if.sv
// rr_hold_scheduler_if
// Bundles the request/grant signals shared between the requesting agents
// and the round-robin hold scheduler.
//
// Signals:
//   req            N_REQ  per-requester request level (held while ownership is wanted)
//   release_strobe N_REQ  per-requester one-cycle release strobe; only the owner's
//                         bit matters ("release" is a reserved word in SystemVerilog,
//                         hence the longer name)
//   grant          N_REQ  one-hot grant, all-zero when nobody owns the resource
//   grant_valid    1      high when any grant bit is set
//   grant_id       ID_W   index of the current owner, 0 when grant_valid is low
//   timeout_pulse  1      one-cycle pulse when an owner is forcibly revoked
//
// Modports:
//   master - requester side (drives req/release_strobe)
//   slave  - scheduler side (drives grant outputs)

interface rr_hold_scheduler_if #(
   parameter int N_REQ = 3,
   parameter int ID_W  = 2
);
   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] release_strobe;
   logic [N_REQ-1:0] grant;
   logic             grant_valid;
   logic [ID_W-1:0]  grant_id;
   logic             timeout_pulse;

   modport master (
      output req,
      output release_strobe,
      input  grant,
      input  grant_valid,
      input  grant_id,
      input  timeout_pulse
   );

   modport slave (
      input  req,
      input  release_strobe,
      output grant,
      output grant_valid,
      output grant_id,
      output timeout_pulse
   );
endinterface

// File: rtl/rr_hold_scheduler.sv
// rr_hold_scheduler
// Round-robin scheduler for one non-preemptible resource shared by N_REQ
// requesters. The winner keeps ownership over many cycles until it pulses
// its release strobe or drops its request; priority then rotates to the
// requester after the last owner. grant_id drives the resource select mux.
// There is always one idle cycle between successive owners.
//
// Ports:
//   clock     rising-edge clock
//   reset_an  asynchronous active-low reset
//   bus       rr_hold_scheduler_if.slave (req, release_strobe in;
//             grant, grant_valid, grant_id, timeout_pulse out, all registered)
//
// Parameters:
//   N_REQ     number of requesters (2..8)
//   ID_W      width of grant_id, 2**ID_W >= N_REQ
//   MAX_HOLD  longest ownership in cycles when the hold limit is built in (2..255)
//
// Optional feature (macro RR_HOLD_SCHED_TIMEOUT_EN):
//   Defined   - an owner that holds for MAX_HOLD cycles is revoked, timeout_pulse
//               fires for one cycle and the owner is masked until it drops req.
//   Undefined - no hold limit, timeout_pulse is constant 0, no masking.

module rr_hold_scheduler #(
   parameter int N_REQ    = 3,
   parameter int ID_W     = 2,
   parameter int MAX_HOLD = 16
) (
   input logic                clock,
   input logic                reset_an,
   rr_hold_scheduler_if.slave bus
);

   typedef enum logic {IDLE, OWN} state_t;

   localparam logic [7:0]       HOLD_LAST = 8'(MAX_HOLD - 1);
   localparam logic [N_REQ-1:0] ONE_HOT0  = N_REQ'(1);

   state_t           state;
   logic [ID_W-1:0]  pointer;
   logic [ID_W-1:0]  owner;
   logic [N_REQ-1:0] grant_r;
   logic             valid_r;
   logic             pulse_r;
   logic [7:0]       hold_cnt;
   logic [N_REQ-1:0] mask;

   logic [N_REQ-1:0] eff_req;
   logic             found;
   logic [ID_W-1:0]  win_id;
   logic             owner_done;
   logic [ID_W-1:0]  ptr_after_owner;

`ifdef RR_HOLD_SCHED_TIMEOUT_EN
   logic [N_REQ-1:0] owner_bit;
   assign owner_bit = ONE_HOT0 << owner;
`else
   assign mask = '0;
`endif

   assign eff_req = bus.req & ~mask;

   // Rotating priority search: the first eligible requester starting at
   // pointer and wrapping modulo N_REQ wins.
   always_comb begin
      found  = 1'b0;
      win_id = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!found && eff_req[(int'(pointer) + k) % N_REQ]) begin
            found  = 1'b1;
            win_id = ID_W'((int'(pointer) + k) % N_REQ);
         end
      end
   end

   // Normal end of ownership: the owner releases or withdraws its request.
   // Strobes and request changes from anyone else are irrelevant here.
   assign owner_done      = bus.release_strobe[owner] | ~bus.req[owner];
   assign ptr_after_owner = (int'(owner) == N_REQ - 1) ? '0 : owner + ID_W'(1);

   // Scheduler FSM with all outputs registered. Entering IDLE always
   // spends one cycle there, giving the guaranteed gap between owners.
   // Without the hold limit, hold_cnt simply saturates and has no effect.
   always_ff @(posedge clock or negedge reset_an) begin
      if (!reset_an) begin
         state    <= IDLE;
         pointer  <= '0;
         owner    <= '0;
         grant_r  <= '0;
         valid_r  <= 1'b0;
         pulse_r  <= 1'b0;
         hold_cnt <= '0;
`ifdef RR_HOLD_SCHED_TIMEOUT_EN
         mask     <= '0;
`endif
      end else begin
         pulse_r <= 1'b0;
`ifdef RR_HOLD_SCHED_TIMEOUT_EN
         mask    <= mask & bus.req;
`endif
         case (state)
            IDLE: begin
               if (found) begin
                  grant_r  <= ONE_HOT0 << win_id;
                  valid_r  <= 1'b1;
                  owner    <= win_id;
                  hold_cnt <= '0;
                  state    <= OWN;
               end
            end
            OWN: begin
               if (owner_done) begin
                  grant_r <= '0;
                  valid_r <= 1'b0;
                  owner   <= '0;
                  pointer <= ptr_after_owner;
                  state   <= IDLE;
               end
`ifdef RR_HOLD_SCHED_TIMEOUT_EN
               else if (hold_cnt == HOLD_LAST) begin
                  grant_r <= '0;
                  valid_r <= 1'b0;
                  owner   <= '0;
                  pointer <= ptr_after_owner;
                  pulse_r <= 1'b1;
                  mask    <= (mask & bus.req) | owner_bit;
                  state   <= IDLE;
               end
`endif
               else if (hold_cnt != HOLD_LAST) begin
                  hold_cnt <= hold_cnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.grant         = grant_r;
   assign bus.grant_valid   = valid_r;
   assign bus.grant_id      = owner;
   assign bus.timeout_pulse = pulse_r;

endmodule

// File: tb/tb_rr_hold_scheduler.sv
// tb_rr_hold_scheduler
// Self-checking bench for rr_hold_scheduler. A behavioural model (owner as an
// integer, pointer, hold count, mask array) predicts grant, grant_valid,
// grant_id and timeout_pulse each cycle; directed scenarios and a random
// run compare the DUT against it and against hand-derived constants.
// Scenarios for RR_HOLD_SCHED_TIMEOUT_EN are compiled only with that macro.

module tb_rr_hold_scheduler;

   localparam int N_REQ    = 3;
   localparam int ID_W     = 2;
   localparam int MAX_HOLD = 16;
   localparam int VW       = N_REQ + 1 + ID_W + 1;

   logic clock    = 1'b0;
   logic reset_an = 1'b0;
   int   total    = 0;
   int   bad      = 0;

   rr_hold_scheduler_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus ();

   rr_hold_scheduler #(.N_REQ(N_REQ), .ID_W(ID_W), .MAX_HOLD(MAX_HOLD)) dut (
      .clock    (clock),
      .reset_an (reset_an),
      .bus      (bus)
   );

   // Free-running clock, period 10.
   always #5 clock = ~clock;

   logic [VW-1:0] observed;
   assign observed = {bus.grant, bus.grant_valid, bus.grant_id, bus.timeout_pulse};

   // Reference model state: m_owner = -1 means nobody owns the resource.
   int m_owner;
   int m_ptr;
   int m_hold;
   bit m_mask [N_REQ];
   bit m_pulse;

   function automatic void model_reset();
      m_owner = -1;
      m_ptr   = 0;
      m_hold  = 0;
      m_pulse = 1'b0;
      for (int i = 0; i < N_REQ; i++) m_mask[i] = 1'b0;
   endfunction

   // One clock edge of the scheduling rules, applied to the inputs seen at that edge.
   function automatic void model_step(logic [N_REQ-1:0] r, logic [N_REQ-1:0] rl);
      bit nmask [N_REQ];
      for (int i = 0; i < N_REQ; i++) nmask[i] = m_mask[i] && r[i];
      m_pulse = 1'b0;
      if (m_owner < 0) begin
         for (int k = 0; k < N_REQ; k++) begin
            int cand;
            cand = (m_ptr + k) % N_REQ;
            if (m_owner < 0 && r[cand] && !m_mask[cand]) begin
               m_owner = cand;
               m_hold  = 0;
            end
         end
      end else if (rl[m_owner] || !r[m_owner]) begin
         m_ptr   = (m_owner + 1) % N_REQ;
         m_owner = -1;
      end
`ifdef RR_HOLD_SCHED_TIMEOUT_EN
      else if (m_hold == MAX_HOLD - 1) begin
         nmask[m_owner] = 1'b1;
         m_pulse = 1'b1;
         m_ptr   = (m_owner + 1) % N_REQ;
         m_owner = -1;
      end
`endif
      else begin
         m_hold++;
      end
      for (int i = 0; i < N_REQ; i++) m_mask[i] = nmask[i];
   endfunction

   function automatic logic [VW-1:0] model_vec();
      logic [N_REQ-1:0] g;
      logic [ID_W-1:0]  id;
      g  = '0;
      id = '0;
      if (m_owner >= 0) begin
         g[m_owner] = 1'b1;
         id = ID_W'(m_owner);
      end
      return {g, (m_owner >= 0), id, m_pulse};
   endfunction

   task automatic applyStimulus(input logic [N_REQ-1:0] r, input logic [N_REQ-1:0] rl);
      bus.req            = r;
      bus.release_strobe = rl;
   endtask

   // Advance one clock: the model sees the same inputs as the DUT at the edge,
   // outputs are then sampled on the falling edge.
   task automatic tick();
      @(posedge clock);
      model_step(bus.req, bus.release_strobe);
      @(negedge clock);
   endtask

   task automatic do_reset();
      reset_an = 1'b0;
      applyStimulus('0, '0);
      model_reset();
      repeat (2) @(negedge clock);
      reset_an = 1'b1;
   endtask

   task automatic test_reset();
      reset_an = 1'b0;
      applyStimulus(3'b111, 3'b111);
      model_reset();
      @(negedge clock);
      total++;
      if (observed !== '0) begin
         bad++;
         $display("[TB] FAIL reset_state: got %b want %b", observed, {VW{1'b0}});
      end
      applyStimulus('0, '0);
      reset_an = 1'b1;
      tick();
      total++;
      if (observed !== model_vec()) begin
         bad++;
         $display("[TB] FAIL reset_idle: got %b want %b", observed, model_vec());
      end
   endtask

   task automatic test_rotation();
      logic [N_REQ-1:0] rl;
      logic prev_valid;
      int   starts[$];
      do_reset();
      prev_valid = 1'b0;
      for (int c = 0; c < 25; c++) begin
         rl = '0;
         if (m_owner >= 0 && m_hold == 3) rl = N_REQ'(1) << m_owner;
         applyStimulus(3'b111, rl);
         tick();
         total++;
         if (observed !== model_vec()) begin
            bad++;
            $display("[TB] FAIL rotation cycle %0d: got %b want %b", c, observed, model_vec());
         end
         if (bus.grant_valid === 1'b1 && !prev_valid) starts.push_back(int'(bus.grant_id));
         prev_valid = (bus.grant_valid === 1'b1);
      end
      total++;
      if (starts.size() < 4 || starts[0] != 0 || starts[1] != 1 || starts[2] != 2 || starts[3] != 0) begin
         bad++;
         $display("[TB] FAIL rotation_order: got %p want 0,1,2,0", starts);
      end
   endtask

   task automatic test_nonowner();
      do_reset();
      applyStimulus(3'b010, '0);
      tick();
      total++;
      if (observed !== model_vec()) begin
         bad++;
         $display("[TB] FAIL nonowner_grant: got %b want %b", observed, model_vec());
      end
      for (int c = 0; c < 6; c++) begin
         applyStimulus(3'b111, N_REQ'($urandom) & 3'b101);
         tick();
         total++;
         if (bus.grant !== 3'b010 || observed !== model_vec()) begin
            bad++;
            $display("[TB] FAIL nonowner_hold cycle %0d: got %b want %b", c, observed, model_vec());
         end
      end
      applyStimulus(3'b101, '0);
      tick();
      total++;
      if (observed !== model_vec()) begin
         bad++;
         $display("[TB] FAIL nonowner_gap: got %b want %b", observed, model_vec());
      end
      tick();
      total++;
      if (bus.grant !== 3'b100 || observed !== model_vec()) begin
         bad++;
         $display("[TB] FAIL nonowner_next: got %b want %b", observed, model_vec());
      end
   endtask

   task automatic test_wrap();
      do_reset();
      applyStimulus(3'b100, '0);
      tick();
      total++;
      if (bus.grant !== 3'b100 || observed !== model_vec()) begin
         bad++;
         $display("[TB] FAIL wrap_grant: got %b want %b", observed, model_vec());
      end
      tick();
      applyStimulus(3'b100, 3'b100);
      tick();
      total++;
      if (observed !== model_vec()) begin
         bad++;
         $display("[TB] FAIL wrap_release: got %b want %b", observed, model_vec());
      end
      applyStimulus(3'b110, '0);
      tick();
      total++;
      if (bus.grant !== 3'b010 || observed !== model_vec()) begin
         bad++;
         $display("[TB] FAIL wrap_pointer: got %b want %b", observed, model_vec());
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      applyStimulus(3'b001, '0);
      tick();
      tick();
      #2 reset_an = 1'b0;
      #1;
      total++;
      if (observed !== '0) begin
         bad++;
         $display("[TB] FAIL async_reset_drop: got %b want %b", observed, {VW{1'b0}});
      end
      model_reset();
      applyStimulus(3'b011, '0);
      @(negedge clock);
      reset_an = 1'b1;
      tick();
      total++;
      if (bus.grant !== 3'b001 || observed !== model_vec()) begin
         bad++;
         $display("[TB] FAIL async_reset_restart: got %b want %b", observed, model_vec());
      end
   endtask

`ifdef RR_HOLD_SCHED_TIMEOUT_EN
   task automatic test_timeout();
      logic [N_REQ-1:0] r;
      logic [N_REQ-1:0] rl;
      int cnt0;
      int pulses;
      do_reset();
      r      = 3'b011;
      cnt0   = 0;
      pulses = 0;
      for (int c = 0; c < 40; c++) begin
         rl = '0;
         if (m_owner == 1 && m_hold == 2) begin
            rl = 3'b010;
            r  = 3'b001;
         end
         applyStimulus(r, rl);
         tick();
         total++;
         if (observed !== model_vec()) begin
            bad++;
            $display("[TB] FAIL timeout cycle %0d: got %b want %b", c, observed, model_vec());
         end
         if (bus.grant === 3'b001) cnt0++;
         if (bus.timeout_pulse === 1'b1) pulses++;
      end
      total++;
      if (cnt0 != MAX_HOLD || pulses != 1) begin
         bad++;
         $display("[TB] FAIL timeout_length: got hold=%0d pulses=%0d want hold=%0d pulses=1", cnt0, pulses, MAX_HOLD);
      end
      applyStimulus(3'b000, '0);
      tick();
      applyStimulus(3'b001, '0);
      tick();
      total++;
      if (bus.grant !== 3'b001 || observed !== model_vec()) begin
         bad++;
         $display("[TB] FAIL timeout_unmask: got %b want %b", observed, model_vec());
      end
   endtask

   task automatic test_same_edge();
      logic [N_REQ-1:0] rl;
      logic prev_valid;
      int pulses;
      int starts0;
      do_reset();
      pulses     = 0;
      starts0    = 0;
      prev_valid = 1'b0;
      for (int c = 0; c < 40; c++) begin
         rl = '0;
         if (m_owner == 0 && m_hold == MAX_HOLD - 1) rl = 3'b001;
         if (m_owner == 1) rl = 3'b010;
         applyStimulus(3'b011, rl);
         tick();
         total++;
         if (observed !== model_vec()) begin
            bad++;
            $display("[TB] FAIL same_edge cycle %0d: got %b want %b", c, observed, model_vec());
         end
         if (bus.timeout_pulse === 1'b1) pulses++;
         if (bus.grant === 3'b001 && !prev_valid) starts0++;
         prev_valid = (bus.grant_valid === 1'b1);
      end
      total++;
      if (pulses != 0 || starts0 < 2) begin
         bad++;
         $display("[TB] FAIL same_edge_precedence: got pulses=%0d owner0_grants=%0d want pulses=0 owner0_grants>=2", pulses, starts0);
      end
   endtask
`endif

   task automatic test_random();
      logic [N_REQ-1:0] r;
      logic [N_REQ-1:0] rl;
      do_reset();
      r = '0;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N_REQ; i++) begin
            if ($urandom_range(0, 5) == 0) r[i] = ~r[i];
         end
         rl = ($urandom_range(0, 3) == 0) ? N_REQ'($urandom) : '0;
         applyStimulus(r, rl);
         tick();
         total++;
         if (observed !== model_vec()) begin
            bad++;
            $display("[TB] FAIL random cycle %0d: got %b want %b", c, observed, model_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_rotation();
      test_nonowner();
      test_wrap();
      test_async_reset();
`ifdef RR_HOLD_SCHED_TIMEOUT_EN
      test_timeout();
      test_same_edge();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
